// File: rtl/serial_adder_seq_pkg.sv
// Shared definitions for the bit-serial adder.
//   sa_state_e : 2-bit controller state encoding (IDLE=0, RUN=1, DONE=2).
//                Code 3 is unused and recovers to IDLE.
package serial_adder_seq_pkg;

    typedef enum logic [1:0] {
        SA_IDLE = 2'd0,
        SA_RUN  = 2'd1,
        SA_DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_seq_fa.sv
// structuralFullAdder: 1-bit full adder built from two-input gate levels.
// A behavioural full adder with the same ports can replace it without
// touching the serial controller.
//   sum      out 1  a ^ b ^ carryin
//   carryout out 1  majority(a, b, carryin)
//   a        in  1  operand bit A
//   b        in  1  operand bit B
//   carryin  in  1  carry from the previous bit
module structuralFullAdder (
    output logic sum,
    output logic carryout,
    input  logic a,
    input  logic b,
    input  logic carryin
);

    logic ab_xor_s;
    logic ab_and_s;
    logic cx_and_s;

    // First level: half-adder on the two operand bits
    assign ab_xor_s = a ^ b;
    assign ab_and_s = a & b;

    // Second level: fold in the incoming carry
    assign sum      = ab_xor_s ^ carryin;
    assign cx_and_s = ab_xor_s & carryin;

    // Third level: either half-adder stage may generate the carry
    assign carryout = ab_and_s | cx_and_s;

endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial WIDTH-bit adder with start/busy/done handshake.
// Operands are shifted LSB-first through one full-adder cell; the carry is
// held in a flip-flop between bits and sum bits shift into a result register.
//   clk   in  1      rising-edge clock
//   rst_n in  1      synchronous active-low reset
//   start in  1      launches an add when sampled high in IDLE or DONE
//   a     in  WIDTH  operand A (sampled on the accepting edge only)
//   b     in  WIDTH  operand B (sampled on the accepting edge only)
//   cin   in  1      carry-in (sampled on the accepting edge only)
//   busy  out 1      high while in RUN
//   done  out 1      one-cycle pulse when sum/cout become valid
//   sum   out WIDTH  result, held until the next completion or reset
//   cout  out 1      final carry-out, held like sum
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sa_state_e        state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic             c_ff_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] res_next_s;

    structuralFullAdder u_fa (
        .sum      (fa_sum_s),
        .carryout (fa_cout_s),
        .a        (a_sh_r[0]),
        .b        (b_sh_r[0]),
        .carryin  (c_ff_r)
    );

    // New sum bit enters at the MSB; a 1-bit adder has nothing to shift down
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next_s = fa_sum_s;
        end else begin : g_res_wn
            assign res_next_s = {fa_sum_s, res_sh_r[WIDTH-1:1]};
        end
    endgenerate

    // Controller, datapath shift registers, carry flop and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= SA_IDLE;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_sh_r <= '0;
            c_ff_r   <= 1'b0;
            cnt_r    <= '0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
        end else begin
            case (state_r)
                // DONE accepts start exactly like IDLE so back-to-back adds have no bubble
                SA_IDLE, SA_DONE: begin
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        c_ff_r   <= cin;
                        cnt_r    <= '0;
                        res_sh_r <= '0;
                        state_r  <= SA_RUN;
                    end else begin
                        state_r  <= SA_IDLE;
                    end
                end
                SA_RUN: begin
                    res_sh_r <= res_next_s;
                    c_ff_r   <= fa_cout_s;
                    a_sh_r   <= a_sh_r >> 1'b1;
                    b_sh_r   <= b_sh_r >> 1'b1;
                    cnt_r    <= cnt_r + CNT_ONE;
                    // Outputs update only here, so they never expose partial bits
                    if (cnt_r == LAST_CNT) begin
                        sum_r   <= res_next_s;
                        cout_r  <= fa_cout_s;
                        state_r <= SA_DONE;
                    end else begin
                        state_r <= SA_RUN;
                    end
                end
                default: begin
                    state_r <= SA_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r == SA_RUN);
    assign done = (state_r == SA_DONE);
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq (WIDTH=8, clock period 400).
// Directed vectors with hand-computed results; outputs sampled on the
// falling edge, inputs driven on the falling edge.
module tb_serial_adder_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int         checks;
    int         failures;
    logic [7:0] last_sum;
    logic       last_cout;
    int         lat;

    serial_adder_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #200 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on the negedge after the accepting edge (count 1); returns the
    // negedge count at which done is seen. Checks busy stays high and the
    // previous result is held meanwhile. Optionally pulses start mid-run.
    task automatic wait_done(input int pulse_at, output int n);
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            check_eq("busy_during_run", {31'd0, busy}, 32'd1);
            check_eq("sum_held", {24'd0, sum}, {24'd0, last_sum});
            check_eq("cout_held", {31'd0, cout}, {31'd0, last_cout});
            if (n == pulse_at) begin
                start = 1'b1;
                a     = 8'h3C;
                b     = 8'h42;
            end else if (n == pulse_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run_add(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic tc, input logic [7:0] es, input logic ec,
                           input int pulse_at);
        int n;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble operands: they must have been captured on the accepting edge
        a = ~ta; b = ~tb_v; cin = ~tc;
        wait_done(pulse_at, n);
        check_eq({tag, "_latency"}, n, 32'd9);
        check_eq({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
        last_sum  = es;
        last_cout = ec;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        last_sum = 8'h00; last_cout = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_sum", {24'd0, sum}, 32'd0);
        check_eq("rst_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;

        run_add("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, -1);
        run_add("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
        run_add("a5_5a",  8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, -1);
        run_add("3c_42",  8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, -1);
        run_add("mixed",  8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, -1);
        // start pulse 3 cycles into RUN with 3C/42 must be ignored
        run_add("ignore", 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 3);

        // Reset during RUN cycle 4 discards the add and clears outputs
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_sum", {24'd0, sum}, 32'd0);
        check_eq("abort_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        last_sum = 8'h00; last_cout = 1'b0;
        run_add("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, -1);

        // start held high through DONE: second add starts with no idle cycle
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done(-1, lat);
        check_eq("b2b_first_latency", lat, 32'd9);
        check_eq("b2b_first_sum", {24'd0, sum}, 32'h30);
        a = 8'hF0; b = 8'h1B; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b_no_bubble", {31'd0, busy}, 32'd1);
        check_eq("b2b_done_low", {31'd0, done}, 32'd0);
        last_sum = 8'h30; last_cout = 1'b0;
        wait_done(-1, lat);
        check_eq("b2b_gap", lat, 32'd9);
        check_eq("b2b_second_sum", {24'd0, sum}, 32'h0C);
        check_eq("b2b_second_cout", {31'd0, cout}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
